// File: rtl/dds_pkg.sv
// Shared types and constants for the DDS sweep controller.
package dds_pkg;

  // Angles are in degrees; anything at or above a full turn is invalid.
  localparam logic [8:0] PHASE_MAX = 9'd360;

  // Width of the dwell field held in each table entry.
  localparam int SEG_DWELL_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DWELL = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef struct packed {
    logic [8:0]             fword;
    logic [8:0]             phase;
    logic [SEG_DWELL_W-1:0] dwell;
  } seg_t;

endpackage

// File: rtl/dds_sweep_ctrl.sv
// Segment-table frequency sweeper: steps a DDS through NUM_SEG
// {fword, phase, dwell} entries, pulsing the DDS reset on every load.
// DWELL_W must match dds_pkg::SEG_DWELL_W.
module dds_sweep_ctrl
  import dds_pkg::*;
#(
  parameter int NUM_SEG = 4,
  parameter int DWELL_W = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cfg_we,
  input  logic [$clog2(NUM_SEG)-1:0] cfg_addr,
  input  logic [8:0]                 cfg_fword,
  input  logic [8:0]                 cfg_phase,
  input  logic [DWELL_W-1:0]         cfg_dwell,
  output logic                       cfg_err,
  input  logic                       start,
  input  logic                       stop,
  input  logic                       loop_en,
  output logic                       busy,
  output logic                       done,
  output logic [$clog2(NUM_SEG)-1:0] seg_idx,
  output logic [8:0]                 f_word,
  output logic [8:0]                 phase_init,
  output logic                       dds_rstn
);

  localparam int SW = $clog2(NUM_SEG);

  state_t             state;
  seg_t               tbl [NUM_SEG];
  logic [DWELL_W-1:0] cnt;
  logic [DWELL_W-1:0] cur_dwell;
  logic [DWELL_W-1:0] dwell_last;
  logic               last_seg;
  logic [SW-1:0]      nxt_seg;
  logic               wr_bad;

  // Dwell of 0 behaves as 1, so the last count index is max(dwell,1)-1.
  always_comb begin
    cur_dwell  = DWELL_W'(tbl[seg_idx].dwell);
    dwell_last = (cur_dwell == '0) ? '0 : cur_dwell - DWELL_W'(1);
    last_seg   = (seg_idx == SW'(NUM_SEG - 1));
    nxt_seg    = last_seg ? '0 : seg_idx + SW'(1);
    wr_bad     = busy || (cfg_fword >= PHASE_MAX) || (cfg_phase >= PHASE_MAX) ||
                 (int'(cfg_addr) >= NUM_SEG);
  end

  // Table writes, sweep FSM and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      seg_idx    <= '0;
      f_word     <= '0;
      phase_init <= '0;
      dds_rstn   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      cfg_err    <= 1'b0;
      cnt        <= '0;
      for (int i = 0; i < NUM_SEG; i++) tbl[i] <= '0;
    end else begin
      cfg_err <= 1'b0;
      done    <= 1'b0;

      if (cfg_we) begin
        if (wr_bad) cfg_err <= 1'b1;
        else        tbl[cfg_addr] <= '{fword: cfg_fword, phase: cfg_phase,
                                       dwell: SEG_DWELL_W'(cfg_dwell)};
      end

      if (stop) begin
        state      <= IDLE;
        busy       <= 1'b0;
        f_word     <= '0;
        phase_init <= '0;
        dds_rstn   <= 1'b0;
      end else begin
        case (state)
          IDLE: if (start) begin
            state      <= LOAD;
            seg_idx    <= '0;
            f_word     <= tbl[0].fword;
            phase_init <= tbl[0].phase;
            dds_rstn   <= 1'b0;
            busy       <= 1'b1;
            cnt        <= '0;
          end
          LOAD: begin
            state    <= DWELL;
            dds_rstn <= 1'b1;
            cnt      <= '0;
          end
          DWELL: begin
            if (cnt == dwell_last) begin
              if (last_seg && !loop_en) begin
                state      <= DONE;
                done       <= 1'b1;
                busy       <= 1'b0;
                f_word     <= '0;
                phase_init <= '0;
                dds_rstn   <= 1'b0;
              end else begin
                state      <= LOAD;
                seg_idx    <= nxt_seg;
                f_word     <= tbl[nxt_seg].fword;
                phase_init <= tbl[nxt_seg].phase;
                dds_rstn   <= 1'b0;
                cnt        <= '0;
              end
            end else begin
              cnt <= cnt + DWELL_W'(1);
            end
          end
          DONE: state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
